// File: rtl/reg_bank_20x32.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_20x32
// Purpose  : Register storage stage that feeds a 32-way, 20-bit select mux.
//            Holds 32 x 20-bit registers and presents all of them in
//            parallel on a packed bus.
//            It has one write port with a valid/ready handshake.
//            It also supports a sequential bulk clear that takes 32 cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W   : register width (must match the downstream mux data width)
//   ADDR_W   : address width; NUM_REGS = 2**ADDR_W
// Ports
//   clk      : in   clock, all state changes on the rising edge
//   rst      : in   synchronous active-high reset
//   wr_valid : in   write request
//   wr_ready : out  bank can accept a write this cycle (IDLE)
//   wr_addr  : in   target register index
//   wr_data  : in   data to write
//   clr_req  : in   start a bulk clear (sampled in IDLE only)
//   clr_busy : out  bulk clear in progress (CLEAR)
//   regs     : out  packed register contents, element i = register i
//   wr_mask  : out  bit i set if register i written since reset/clear
// Build option
//   REG_BANK_ZERO_EN : when defined, register 0 reads as constant zero and
//                      its mask bit stays zero. Writes to address 0 still
//                      complete the handshake, but their data is dropped.
// ============================================================================
module reg_bank_20x32 #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic                                  clr_req,
  output logic                                  clr_busy,
  output logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
  output logic [(2**ADDR_W)-1:0]                wr_mask
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Sweep terminal count: the last register index.
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NUM_REGS - 1);

  // State encoding
  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_clear = 1'b1;

  logic [0:0]                         r_state;
  logic [0:0]                         w_state_nxt;
  logic [ADDR_W-1:0]                  r_cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0]    r_regs;
  logic [NUM_REGS-1:0]                r_mask;
  logic                               w_wr_fire;
  logic                               w_sweep_done;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  assign w_sweep_done = (r_cnt == c_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (clr_req) begin
          w_state_nxt = c_clear;
        end
      end
      c_clear: begin
        // The final register is cleared on the same edge as the exit.
        if (w_sweep_done) begin
          w_state_nxt = c_idle;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (combinational decode of the current state)
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ready = 1'b0;
    clr_busy = 1'b0;
    case (r_state)
      c_idle:  wr_ready = 1'b1;
      c_clear: clr_busy = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  assign w_wr_fire = wr_valid & wr_ready;

  // --------------------------------------------------------------------------
  // Sweep counter. It starts from zero on entry to CLEAR. On the terminal
  // edge it parks at zero again, so the counter never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == c_clear) && !w_sweep_done) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Register storage and written-mask.
  // A write can only fire in IDLE and the sweep only runs in CLEAR, so the
  // two updates never target the same edge. A write that coincides with
  // clr_req commits on the IDLE edge, and the sweep zeroes it later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_mask <= '0;
    end else begin
`ifdef REG_BANK_ZERO_EN
      // Register 0 is never loaded, so it holds its reset value of zero.
      if (w_wr_fire && (wr_addr != '0)) begin
        r_regs[wr_addr] <= wr_data;
        r_mask[wr_addr] <= 1'b1;
      end
`else
      if (w_wr_fire) begin
        r_regs[wr_addr] <= wr_data;
        r_mask[wr_addr] <= 1'b1;
      end
`endif
      if (r_state == c_clear) begin
        r_regs[r_cnt] <= '0;
        r_mask[r_cnt] <= 1'b0;
      end
    end
  end

  assign regs    = r_regs;
  assign wr_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_20x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_20x32
// Purpose  : Self-checking bench for reg_bank_20x32. Stimulus queues the
//            expected values together with the cycle at which each must
//            hold. A monitor checks every due entry on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_20x32;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

`ifdef REG_BANK_ZERO_EN
  localparam logic [31:0] c_full_mask = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] c_full_mask = 32'hFFFF_FFFF;
`endif

  // Kinds of observation
  localparam int K_REG   = 0;
  localparam int K_MASK  = 1;
  localparam int K_READY = 2;
  localparam int K_BUSY  = 3;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              wr_valid;
  logic                              wr_ready;
  logic [ADDR_W-1:0]                 wr_addr;
  logic [DATA_W-1:0]                 wr_data;
  logic                              clr_req;
  logic                              clr_busy;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs;
  logic [NUM_REGS-1:0]               wr_mask;

  reg_bank_20x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .regs     (regs),
    .wr_mask  (wr_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  bit   draining = 1'b0;
  logic [31:0] act;

  // Queue an expectation that must hold "dly" cycles from now.
  task automatic expect_at(input string nm, input int kind, input int idx,
                           input logic [31:0] exp, input int dly);
    chk_t c;
    c.due  = cyc + dly;
    c.name = nm;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    sbq.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        case (sbq[i].kind)
          K_REG:   act = 32'(regs[sbq[i].idx]);
          K_MASK:  act = 32'(wr_mask);
          K_READY: act = 32'(wr_ready);
          default: act = 32'(clr_busy);
        endcase
        checks++;
        if (act !== sbq[i].exp) begin
          failures++;
          $display("FAIL %s idx=%0d cyc=%0d got=0x%0h expected=0x%0h",
                   sbq[i].name, sbq[i].idx, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end else if (draining) begin
        checks++;
        failures++;
        $display("FAIL %s idx=%0d never checked: got=none expected=0x%0h",
                 sbq[i].name, sbq[i].idx, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  // Pre-clear content after fill and overwrite: data = address, reg 4 = 0x12345.
  function automatic logic [31:0] filled(input int k);
    if (k == 4) return 32'h12345;
    return 32'(k);
  endfunction

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    for (int i = 0; i < NUM_REGS; i++) expect_at("rst_reg", K_REG, i, 32'h0, 0);
    expect_at("rst_mask",  K_MASK,  0, 32'h0, 0);
    expect_at("rst_ready", K_READY, 0, 32'h1, 0);
    expect_at("rst_busy",  K_BUSY,  0, 32'h0, 0);
    tick();

    // ---------------- sequential fill ----------------
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
      expect_at("fill_pre", K_REG, i, 32'h0, 0);
`ifdef REG_BANK_ZERO_EN
      expect_at("fill", K_REG, i, (i == 0) ? 32'h0 : 32'(i), 1);
`else
      expect_at("fill", K_REG, i, 32'(i), 1);
`endif
      tick();
    end
    wr_valid = 1'b0;
    expect_at("fill_mask", K_MASK, 0, c_full_mask, 0);
    tick();

    // ---------------- overwrite + mux selects ----------------
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 20'hABCDE;
    expect_at("ovw_first", K_REG, 4, 32'hABCDE, 1);
    tick();
    wr_data = 20'h12345;
    expect_at("ovw_last", K_REG, 4, 32'h12345, 1);
    tick();
    wr_valid = 1'b0;
    expect_at("mux_sel0",  K_REG, 0,  32'h0, 0);
    expect_at("mux_sel1",  K_REG, 1,  32'h1, 0);
    expect_at("mux_sel2",  K_REG, 2,  32'h2, 0);
    expect_at("mux_sel4",  K_REG, 4,  32'h12345, 0);
    expect_at("mux_sel31", K_REG, 31, 32'h1F, 0);
    tick();

    // ---------------- bulk clear with held write ----------------
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 20'hFFFFF;
    for (int k = 0; k < NUM_REGS; k++) begin
      expect_at("clr_busy",  K_BUSY,  0, 32'h1, 0);
      expect_at("clr_ready", K_READY, 0, 32'h0, 0);
      expect_at("clr_unswept", K_REG, k, filled(k), 0);
      if (k > 0) expect_at("clr_swept", K_REG, k - 1, 32'h0, 0);
      tick();
    end
    expect_at("clr_end_busy",  K_BUSY,  0, 32'h0, 0);
    expect_at("clr_end_ready", K_READY, 0, 32'h1, 0);
    expect_at("held_not_early", K_REG, 7, 32'h0, 0);
    tick();
    wr_valid = 1'b0;
    expect_at("held_commit", K_REG, 7, 32'hFFFFF, 0);
    expect_at("clr_mask", K_MASK, 0, 32'h0000_0080, 0);
    for (int i = 0; i < NUM_REGS; i++)
      if (i != 7) expect_at("clr_zero", K_REG, i, 32'h0, 0);
    tick();

    // ---------------- simultaneous write + clear ----------------
    wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 20'h55555;
    clr_req = 1'b1;
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    expect_at("sim_mask", K_MASK, 0, 32'h8000_0080, 0);
    for (int k = 0; k < NUM_REGS; k++) begin
      expect_at("sim_hold", K_REG, 31, 32'h55555, 0);
      expect_at("sim_busy", K_BUSY, 0, 32'h1, 0);
      tick();
    end
    expect_at("sim_cleared", K_REG, 31, 32'h0, 0);
    expect_at("sim_reg7",    K_REG, 7,  32'h0, 0);
    expect_at("sim_busy_end", K_BUSY, 0, 32'h0, 0);
    expect_at("sim_mask_end", K_MASK, 0, 32'h0, 0);
    tick();

    // ---------------- reset mid-clear ----------------
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i + 100);
      tick();
    end
    wr_valid = 1'b0;
    expect_at("refill_mask", K_MASK, 0, c_full_mask, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    expect_at("mid_unswept", K_REG, 20, 32'd120, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) expect_at("mid_rst_reg", K_REG, i, 32'h0, 0);
    expect_at("mid_rst_mask",  K_MASK,  0, 32'h0, 0);
    expect_at("mid_rst_busy",  K_BUSY,  0, 32'h0, 0);
    expect_at("mid_rst_ready", K_READY, 0, 32'h1, 0);
    tick(); tick();
    expect_at("no_resume_busy", K_BUSY, 0, 32'h0, 0);
    tick(); tick();

    // Flush anything still pending.
    draining = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
